// File: rtl/taxi_eth_mcf_pkg.sv
// MAC control frame constants shared by the receive parser and the pause timer bank.
// Prescale defaults are clock cycles per 512-bit-time quantum, minus 1.
package taxi_eth_mcf_pkg;

    localparam logic [15:0] McfEthertype = 16'h8808;
    localparam logic [15:0] McfOpcodeLfc = 16'h0001;
    localparam logic [15:0] McfOpcodePfc = 16'h0101;
    localparam logic [47:0] McfPfcDstMac = 48'h0180C2000001;

    localparam int unsigned QuantumBitTimes = 512;

    localparam logic [7:0] PrescaleMiiNibble = 8'd127;
    localparam logic [7:0] PrescaleGmiiByte  = 8'd63;
    localparam logic [7:0] PrescaleByte100m  = 8'd63;
    localparam logic [7:0] PrescaleWord32    = 8'd15;
    localparam logic [7:0] PrescaleWord64    = 8'd7;

    // Prescale setting for a datapath carrying dp_width bits per clock.
    function automatic logic [7:0] quanta_prescale(input int unsigned dp_width);
        int unsigned cycles;
        cycles = QuantumBitTimes / dp_width;
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/taxi_eth_pause_timer_ch.sv
// Single pause channel: quanta timer with load-over-decrement priority and
// registered stat pulses for the accepted load.
module taxi_eth_pause_timer_ch
    import taxi_eth_mcf_pkg::*;
#(
    parameter int unsigned QUANTA_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                tick_i,
    input  logic                load_i,
    input  logic [QUANTA_W-1:0] load_quanta_i,
    input  logic                pause_ack_i,
    output logic                pause_req_o,
    output logic                stat_xon_o,
    output logic                stat_xoff_o,
    output logic                stat_paused_o
);

    logic [QUANTA_W-1:0] timer_q, timer_d;
    logic                xon_q, xon_d;
    logic                xoff_q, xoff_d;
    logic                paused_q, paused_d;

    assign pause_req_o   = (timer_q != '0);
    assign stat_xon_o    = xon_q;
    assign stat_xoff_o   = xoff_q;
    assign stat_paused_o = paused_q;

    always_comb begin
        timer_d  = timer_q;
        xon_d    = 1'b0;
        xoff_d   = 1'b0;
        paused_d = pause_req_o & pause_ack_i;
        if (!enable_i) begin
            timer_d = '0;
        end else if (load_i) begin
            // A new frame restarts the pause rather than adding to it.
            timer_d = load_quanta_i;
            xon_d   = (load_quanta_i == '0);
            xoff_d  = (load_quanta_i != '0);
        end else if (tick_i && timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q  <= '0;
            xon_q    <= 1'b0;
            xoff_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            xon_q    <= xon_d;
            xoff_q   <= xoff_d;
            paused_q <= paused_d;
        end
    end

endmodule

// File: rtl/taxi_eth_pfc_pause_timer.sv
// Receive-side pause quanta timer bank: shared quantum prescaler plus CH_CNT
// independent channel timers (CH_CNT=1 for LFC, 8 for PFC).
module taxi_eth_pfc_pause_timer
    import taxi_eth_mcf_pkg::*;
#(
    parameter int unsigned CH_CNT     = 8,
    parameter int unsigned QUANTA_W   = 16,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_enable,
    input  logic [PRESCALE_W-1:0]        cfg_quanta_prescale,
    input  logic                         load_valid,
    input  logic [CH_CNT-1:0]            load_en,
    input  logic [CH_CNT*QUANTA_W-1:0]   load_quanta,
    input  logic [CH_CNT-1:0]            pause_ack,
    output logic [CH_CNT-1:0]            pause_req,
    output logic                         stat_pkt,
    output logic [CH_CNT-1:0]            stat_xon,
    output logic [CH_CNT-1:0]            stat_xoff,
    output logic [CH_CNT-1:0]            stat_paused
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick;
    logic                  pkt_q, pkt_d;
    logic [CH_CNT-1:0]     ch_load;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (!cfg_enable) begin
            presc_d = '0;
        end else if (presc_q == cfg_quanta_prescale) begin
            tick    = 1'b1;
            presc_d = '0;
        end else if (presc_q > cfg_quanta_prescale) begin
            // Prescale was lowered under the running count: restart silently.
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    assign ch_load = (cfg_enable && load_valid) ? load_en : '0;
    assign pkt_d   = |ch_load;
    assign stat_pkt = pkt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            pkt_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pkt_q   <= pkt_d;
        end
    end

    for (genvar i = 0; i < CH_CNT; i++) begin : g_ch
        taxi_eth_pause_timer_ch #(
            .QUANTA_W(QUANTA_W)
        ) u_ch (
            .clk_i         (clk),
            .rst_i         (rst),
            .enable_i      (cfg_enable),
            .tick_i        (tick),
            .load_i        (ch_load[i]),
            .load_quanta_i (load_quanta[i*QUANTA_W +: QUANTA_W]),
            .pause_ack_i   (pause_ack[i]),
            .pause_req_o   (pause_req[i]),
            .stat_xon_o    (stat_xon[i]),
            .stat_xoff_o   (stat_xoff[i]),
            .stat_paused_o (stat_paused[i])
        );
    end

endmodule

// File: doc/taxi_eth_pfc_pause_timer.md
Name: taxi_eth_pfc_pause_timer

Overview:
- Receive-side pause quanta timer bank for the 10M/100M/1G MAC family.
- Generalises the single-channel LFC pause response to CH_CNT independent priority channels. CH_CNT=1 gives 802.3 annex 31B LFC; CH_CNT=8 gives annex 31D PFC.
- Supports a runtime-programmable quantum length, so one instance serves MII nibble, GMII byte and wider datapaths.
- Sits between the MAC control frame (MCF) receive parser and the transmit pause logic. Asserts per-channel pause requests until the loaded quanta expire.

Parameters:
- CH_CNT, 8, number of priority channels (1..8).
- QUANTA_W, 16, pause quanta counter width.
- PRESCALE_W, 8, width of the quantum prescaler (clock cycles per 512 bit times, minus 1).

Ports:
- clk  in  1  datapath clock
- rst  in  1  asynchronous active-high reset
- cfg_enable  in  1  block enable; low clears all timers and ignores loads
- cfg_quanta_prescale  in  PRESCALE_W  clock cycles per pause quantum minus 1 (e.g. 63 for 8-bit at 100M, 127 for MII nibble)
- load_valid  in  1  single-cycle strobe: parsed PFC/LFC frame available
- load_en  in  CH_CNT  per-channel enable vector from the frame
- load_quanta  in  CH_CNT*QUANTA_W  per-channel quanta; channel i at bits [i*QUANTA_W +: QUANTA_W]
- pause_ack  in  CH_CNT  transmit path confirms channel i is currently held off
- pause_req  out  CH_CNT  channel i must be paused
- stat_pkt  out  1  pulse: accepted load with any load_en bit set
- stat_xon  out  CH_CNT  pulse: channel loaded with zero quanta
- stat_xoff  out  CH_CNT  pulse: channel loaded with nonzero quanta
- stat_paused  out  CH_CNT  level: pause_req & pause_ack, registered

Behaviour:
- Reset is asynchronous and active-high. It applies to the clk domain only.
- Reset values: all timers 0, prescaler 0, pause_req 0, all stat outputs 0.

Prescaler:
- Shared counter, 0..cfg_quanta_prescale.
- tick=1 in the cycle where counter == cfg_quanta_prescale; the counter returns to 0 on the next edge.
- If cfg_quanta_prescale is lowered below the current count, the counter wraps to 0 on the next edge without a tick.
- A prescale value of 0 gives a tick every cycle.

Per-channel timer (QUANTA_W bits):
- Load has priority over decrement. If load_valid && load_en[i], timer <= load_quanta[i] regardless of tick or the current value; a running pause is restarted, not accumulated.
- Otherwise, if tick && timer != 0, timer <= timer - 1.
- Decrement saturates at 0; there is no wrap from 0 to max.
- Channels with load_en[i]=0 are unaffected by the load and keep counting.

Outputs and latency:
- pause_req[i] = (timer[i] != 0), combinational from the timer register. Load at edge N gives pause_req at N+1.
- Quanta Q loaded with the prescaler freshly at 0 and prescale P: pause_req stays high for Q*(P+1) cycles, ±(P+1) depending on prescaler phase.
- stat_xon[i] / stat_xoff[i] / stat_pkt are registered one-cycle pulses in the cycle after the accepted load.

Enable and degenerate cases:
- cfg_enable=0: timers and prescaler are forced to 0 synchronously, loads are ignored, and no stat pulses are generated.
- Re-enabling starts from the cleared state.
- load_valid with load_en all zero: no state change and no pulses.
- pause_ack is used only for stat_paused; it never affects counting, per 802.3.
- Reset mid-pause: pause_req drops immediately (asynchronous).

Decomposition:
- Shared package taxi_eth_mcf_pkg holds:
  - MCF constants: LFC opcode 16'h0001, PFC opcode 16'h0101, ethertype 16'h8808, PFC multicast dst 48'h0180C2000001.
  - Quantum bit-time constant 512.
  - Default prescale localparams per speed and datapath width.
- One natural sub-module: taxi_eth_pause_timer_ch, the single-channel load/decrement/stat logic, generated CH_CNT times. The top holds the shared prescaler and enable gating.

Test Plan:
1. cfg_quanta_prescale=3, load ch0 quanta 5 -> pause_req[0] high 1 cycle after load and low after 20 cycles ±4; stat_xoff[0] one pulse; stat_pkt one pulse.
2. Load ch2=10 and ch5=0 in one strobe; ch5 previously running with 7 -> ch2 pauses 10 quanta; ch5 drops next cycle with stat_xon[5]; other channels unchanged.
3. Reload ch1 with 4 while it has 2 remaining, coinciding with a tick -> timer becomes 4 (load wins); pause continues for 4 more quanta.
4. Pause running on ch3, deassert cfg_enable -> pause_req all 0 next cycle; a load issued while disabled has no effect and gives no stat pulses.
5. Assert rst asynchronously mid-pause, between clock edges -> pause_req and all stats 0 immediately; after release, prescaler restarts at 0.
6. CH_CNT=1, QUANTA_W=16, prescale 0, load 16'hFFFF -> exactly 65535 cycles of pause_req, no wrap; stat_paused follows pause_ack while paused.
